rptr_level_handler: RTL and testbench

Read-side pointer controller for the team's async FIFO. It keeps the read pointer in binary and Gray, and derives a registered empty flag from the synchronised write pointer. It also reports read-domain occupancy, a programmable almost-empty flag, a sticky underflow flag and a read-data-valid strobe aligned to the memory's read latency. It sits in the read clock domain between the 2-FF write-pointer synchroniser and the FIFO memory read port.

---
 rtl/rptr_level_handler.sv | 92 +++++++++
 tb/tb_rptr_level_handler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rptr_level_handler.sv
// Read-side pointer controller for the async FIFO: binary/Gray read pointer,
// registered empty/level/almost-empty, sticky underflow and a latency-aligned rvalid.
module rptr_level_handler #(
    parameter int PTR_WIDTH  = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 r_en,
    input  logic [PTR_WIDTH:0]   g_wptr_sync,
    input  logic [PTR_WIDTH:0]   ae_thresh,
    input  logic                 clr_uflow,
    output logic [PTR_WIDTH:0]   b_rptr,
    output logic [PTR_WIDTH-1:0] r_addr,
    output logic [PTR_WIDTH:0]   g_rptr,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   r_level,
    output logic                 rd_fire,
    output logic                 rvalid,
    output logic                 underflow
);
    localparam int PW = PTR_WIDTH + 1;

    logic [PW-1:0] b_next;
    logic [PW-1:0] g_next;
    logic [PW-1:0] w_bin;
    logic [PW-1:0] lvl_next;

    assign rd_fire = r_en & ~empty & ~rrst;
    assign b_next  = b_rptr + {{PTR_WIDTH{1'b0}}, rd_fire};
    assign g_next  = b_next ^ (b_next >> 1);
    assign r_addr  = b_rptr[PTR_WIDTH-1:0];

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_bin = '0;
        for (int i = 0; i < PW; i++) begin
            w_bin[i] = ^(g_wptr_sync >> i);
        end
    end

    // Level uses the post-edge read pointer so a read and a write landing together
    // are each counted once.
    assign lvl_next = w_bin - b_next;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            b_rptr       <= '0;
            g_rptr       <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            r_level      <= '0;
        end else begin
            b_rptr       <= b_next;
            g_rptr       <= g_next;
            empty        <= (g_next == g_wptr_sync);
            almost_empty <= (lvl_next <= ae_thresh);
            r_level      <= lvl_next;
        end
    end

    // Set has priority over clear so a concurrent underflow is never lost.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            underflow <= 1'b0;
        end else if (r_en & empty) begin
            underflow <= 1'b1;
        end else if (clr_uflow) begin
            underflow <= 1'b0;
        end
    end

    generate
        if (RD_LATENCY == 0) begin : g_rv_comb
            assign rvalid = rd_fire;
        end else begin : g_rv_pipe
            logic [RD_LATENCY-1:0] vld_pipe;

            always_ff @(posedge rclk) begin
                if (rrst) begin
                    vld_pipe <= '0;
                end else begin
                    vld_pipe <= (vld_pipe << 1) | RD_LATENCY'(rd_fire);
                end
            end

            assign rvalid = vld_pipe[RD_LATENCY-1];
        end
    endgenerate

endmodule

// File: tb/tb_rptr_level_handler.sv
// Bench for rptr_level_handler at PTR_WIDTH=3, RD_LATENCY=2: integer occupancy
// model for flags/level and an rvalid scoreboard queue.
module tb_rptr_level_handler;
    localparam int PTR_WIDTH  = 3;
    localparam int RD_LATENCY = 2;
    localparam int PW         = PTR_WIDTH + 1;

    logic          rclk = 1'b0;
    logic          rrst = 1'b0;
    logic          r_en = 1'b0;
    logic [PW-1:0] g_wptr_sync = '0;
    logic [PW-1:0] ae_thresh = 4'd2;
    logic          clr_uflow = 1'b0;
    logic [PW-1:0] b_rptr;
    logic [PTR_WIDTH-1:0] r_addr;
    logic [PW-1:0] g_rptr;
    logic          empty, almost_empty, rd_fire, rvalid, underflow;
    logic [PW-1:0] r_level;

    rptr_level_handler #(.PTR_WIDTH(PTR_WIDTH), .RD_LATENCY(RD_LATENCY)) dut (
        .rclk(rclk), .rrst(rrst), .r_en(r_en), .g_wptr_sync(g_wptr_sync),
        .ae_thresh(ae_thresh), .clr_uflow(clr_uflow), .b_rptr(b_rptr),
        .r_addr(r_addr), .g_rptr(g_rptr), .empty(empty),
        .almost_empty(almost_empty), .r_level(r_level), .rd_fire(rd_fire),
        .rvalid(rvalid), .underflow(underflow)
    );

    always #5 rclk = ~rclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: total entries written / read as plain integers.
    int wcnt = 0;
    int rcnt = 0;
    int thr  = 2;
    bit m_empty = 1'b1;
    bit m_ae    = 1'b1;
    bit m_uf    = 1'b0;
    int m_level = 0;
    bit sb_q[$];

    function automatic logic [PW-1:0] gray(input int x);
        logic [PW-1:0] b;
        b = PW'(x);
        return b ^ (b >> 1);
    endfunction

    // Drive one cycle and advance the model; the edge is sampled 1 time unit later.
    task automatic step(input bit ren, input bit clr, input bit rst);
        bit fire;
        r_en = ren; clr_uflow = clr; rrst = rst;
        g_wptr_sync = gray(wcnt); ae_thresh = PW'(thr);
        #1;
        fire = ren && !m_empty && !rst;
        @(posedge rclk); #1;
        if (rst) begin
            rcnt = 0; m_level = 0; m_empty = 1; m_ae = 1; m_uf = 0;
            sb_q.delete();
            sb_q.push_back(1'b0);
        end else begin
            if (ren && m_empty) m_uf = 1;
            else if (clr) m_uf = 0;
            rcnt = rcnt + (fire ? 1 : 0);
            m_level = wcnt - rcnt;
            m_empty = (m_level == 0);
            m_ae = (m_level <= thr);
            sb_q.push_back(fire);
        end
        r_en = 0; clr_uflow = 0; rrst = 0;
    endtask

    always @(negedge rclk) begin
        bit e;
        if (sb_q.size() >= 2) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (rvalid !== e) begin
                n_bad++;
                $display("FAIL sb_rvalid t=%0t got %b want %b", $time, rvalid, e);
            end
        end
    end

    task automatic test_reset;
        wcnt = 0;
        step(0, 0, 1);
        n_cmp++;
        if ({b_rptr, g_rptr, r_level} !== '0) begin
            n_bad++;
            $display("FAIL reset_ptrs got b=%h g=%h lvl=%0d want 0", b_rptr, g_rptr, r_level);
        end
        n_cmp++;
        if ({empty, almost_empty, underflow, rvalid} !== 4'b1100) begin
            n_bad++;
            $display("FAIL reset_flags got e/ae/uf/rv=%b want 1100",
                     {empty, almost_empty, underflow, rvalid});
        end
    endtask

    task automatic test_underflow;
        r_en = 1; #1;
        n_cmp++;
        if (rd_fire !== 1'b0) begin
            n_bad++; $display("FAIL uflow_fire got %b want 0", rd_fire);
        end
        step(1, 0, 0);
        n_cmp++;
        if (underflow !== 1'b1 || b_rptr !== 4'd0) begin
            n_bad++;
            $display("FAIL uflow_set got uf=%b b=%0d want uf=1 b=0", underflow, b_rptr);
        end
        step(0, 1, 0);
        n_cmp++;
        if (underflow !== 1'b0) begin
            n_bad++; $display("FAIL uflow_clr got %b want 0", underflow);
        end
    endtask

    task automatic test_fill_drain;
        wcnt = 3;
        step(0, 0, 0);
        n_cmp++;
        if (empty !== 1'b0 || r_level !== 4'd3 || almost_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL fill3 got e=%b lvl=%0d ae=%b want e=0 lvl=3 ae=0",
                     empty, r_level, almost_empty);
        end
        for (int k = 0; k < 3; k++) begin
            r_en = 1; #1;
            n_cmp++;
            if (rd_fire !== 1'b1) begin
                n_bad++; $display("FAIL drain_fire k=%0d got %b want 1", k, rd_fire);
            end
            step(1, 0, 0);
            n_cmp++;
            if (r_level !== PW'(m_level) || empty !== m_empty || almost_empty !== m_ae) begin
                n_bad++;
                $display("FAIL drain k=%0d got lvl=%0d e=%b ae=%b want lvl=%0d e=%b ae=%b",
                         k, r_level, empty, almost_empty, m_level, m_empty, m_ae);
            end
        end
        r_en = 1; #1;
        n_cmp++;
        if (rd_fire !== 1'b0) begin
            n_bad++; $display("FAIL drain_extra_fire got %b want 0", rd_fire);
        end
        step(1, 0, 0);
        n_cmp++;
        if (b_rptr !== 4'd3 || r_addr !== 3'd3 || underflow !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_extra got b=%0d a=%0d uf=%b want b=3 a=3 uf=1",
                     b_rptr, r_addr, underflow);
        end
        step(0, 1, 0);
    endtask

    task automatic test_ae_boundary;
        wcnt = rcnt + 2;
        step(0, 0, 0);
        n_cmp++;
        if (r_level !== 4'd2 || almost_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL ae_lvl2 got lvl=%0d ae=%b want lvl=2 ae=1", r_level, almost_empty);
        end
        wcnt = rcnt + 3;
        g_wptr_sync = gray(wcnt); #1;
        n_cmp++;
        if (almost_empty !== 1'b1) begin
            n_bad++; $display("FAIL ae_hold got %b want 1", almost_empty);
        end
        step(0, 0, 0);
        n_cmp++;
        if (r_level !== 4'd3 || almost_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL ae_lvl3 got lvl=%0d ae=%b want lvl=3 ae=0", r_level, almost_empty);
        end
    endtask

    task automatic test_wrap;
        logic [PW-1:0] prev_g, prev_b;
        bit saw_wrap = 0;
        step(1, 0, 0);
        for (int k = 0; k < 20; k++) begin
            prev_g = g_rptr; prev_b = b_rptr;
            wcnt++;
            step(1, 0, 0);
            n_cmp++;
            if (b_rptr !== PW'(rcnt) || r_addr !== PTR_WIDTH'(rcnt) || g_rptr !== gray(rcnt)) begin
                n_bad++;
                $display("FAIL wrap_ptr k=%0d got b=%0d g=%h want b=%0d g=%h",
                         k, b_rptr, g_rptr, PW'(rcnt), gray(rcnt));
            end
            n_cmp++;
            if ($countones(prev_g ^ g_rptr) != 1 || empty !== 1'b0 || r_level !== 4'd2) begin
                n_bad++;
                $display("FAIL wrap_step k=%0d got gbits=%0d e=%b lvl=%0d want 1 0 2",
                         k, $countones(prev_g ^ g_rptr), empty, r_level);
            end
            if (prev_b == 4'd15 && b_rptr == 4'd0) saw_wrap = 1;
        end
        n_cmp++;
        if (!saw_wrap) begin
            n_bad++; $display("FAIL wrap_seen got 0 want 1");
        end
        step(1, 0, 0);
        step(1, 0, 0);
        n_cmp++;
        if (empty !== 1'b1 || r_level !== 4'd0) begin
            n_bad++;
            $display("FAIL wrap_stop got e=%b lvl=%0d want e=1 lvl=0", empty, r_level);
        end
    endtask

    task automatic test_full;
        wcnt = 0;
        step(0, 0, 1);
        wcnt = 8;
        step(0, 0, 0);
        n_cmp++;
        if (r_level !== 4'd8 || empty !== 1'b0 || almost_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL full got lvl=%0d e=%b ae=%b want lvl=8 e=0 ae=0",
                     r_level, empty, almost_empty);
        end
    endtask

    task automatic test_latency;
        logic [2:0] seen;
        step(1, 0, 0);
        seen[0] = rvalid;
        step(0, 0, 0);
        seen[1] = rvalid;
        step(0, 0, 0);
        seen[2] = rvalid;
        n_cmp++;
        if (seen !== 3'b010) begin
            n_bad++; $display("FAIL latency got rvalid seq=%b want 010", seen);
        end
    endtask

    task automatic test_reset_inflight;
        step(1, 0, 0);
        wcnt = 0;
        step(1, 0, 1);
        n_cmp++;
        if ({rvalid, empty, almost_empty, underflow} !== 4'b0110 || {b_rptr, g_rptr, r_level} !== '0) begin
            n_bad++;
            $display("FAIL rst_inflight got rv/e/ae/uf=%b b=%0d g=%h lvl=%0d want 0110 0 0 0",
                     {rvalid, empty, almost_empty, underflow}, b_rptr, g_rptr, r_level);
        end
    endtask

    task automatic test_uflow_set_wins;
        step(1, 1, 0);
        n_cmp++;
        if (underflow !== 1'b1) begin
            n_bad++; $display("FAIL uflow_setwins got %b want 1", underflow);
        end
        step(0, 0, 0);
        step(0, 1, 0);
        n_cmp++;
        if (underflow !== m_uf) begin
            n_bad++; $display("FAIL uflow_late_clr got %b want %b", underflow, m_uf);
        end
    endtask

    initial begin
        test_reset();
        test_underflow();
        test_fill_drain();
        test_ae_boundary();
        test_wrap();
        test_full();
        test_latency();
        test_reset_inflight();
        test_uflow_set_wins();
        step(0, 0, 0);
        step(0, 0, 0);
        @(posedge rclk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
